// File: rtl/progmem_reader_pkg.sv
// Shared types and constants for the program-memory block reader.
package progmem_reader_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ADDR_STEP = 32'd4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/progmem_reader_word_fifo.sv
// Synchronous word FIFO; head word is presented directly on rdata.
// A pop on an empty FIFO is dropped, so a same-cycle push only shows up next cycle.
module word_fifo
    import progmem_reader_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [OCC_W-1:0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [OCC_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == OCC_W'(DEPTH));
    assign empty     = (count_r == {OCC_W{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Word storage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {OCC_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + OCC_W'(1);
                2'b01:   count_r <= count_r - OCC_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/progmem_reader.sv
// PicoRV32-bus read initiator: streams word_count words from base_addr
// through a small FIFO onto a valid/ready output.
module progmem_reader
    import progmem_reader_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        mem_wstrb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_r, state_n;
    logic               mem_valid_r, mem_valid_n;
    logic [ADDR_W-1:0]  addr_r, addr_n;
    logic [CNT_W-1:0]   remaining_r, remaining_n;
    logic [TIMER_W-1:0] timer_r, timer_n;
    logic               busy_r, busy_n;
    logic               done_r, done_n;
    logic               err_r, err_n;
    logic               push_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [OCC_W-1:0]   fifo_count_s;
    logic [OCC_W-1:0]   free_slots_s;

    assign free_slots_s = OCC_W'(FIFO_DEPTH) - fifo_count_s;

    // Next-state and next-output decode
    always_comb begin
        state_n     = state_r;
        mem_valid_n = mem_valid_r;
        addr_n      = addr_r;
        remaining_n = remaining_r;
        timer_n     = timer_r;
        busy_n      = busy_r;
        done_n      = 1'b0;
        err_n       = err_r;
        push_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (word_count != {CNT_W{1'b0}})) begin
                    state_n     = REQ;
                    mem_valid_n = 1'b1;
                    addr_n      = {base_addr[ADDR_W-1:2], 2'b00};
                    remaining_n = word_count;
                    timer_n     = {TIMER_W{1'b0}};
                    busy_n      = 1'b1;
                    err_n       = 1'b0;
                end else if (start) begin
                    done_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    push_s      = 1'b1;
                    addr_n      = addr_r + ADDR_STEP;
                    remaining_n = remaining_r - CNT_W'(1);
                    mem_valid_n = 1'b0;
                    state_n     = GAP;
                end else if (timer_r == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    mem_valid_n = 1'b0;
                    err_n       = 1'b1;
                    state_n     = DRAIN;
                end else begin
                    timer_n = timer_r + TIMER_W'(1);
                end
            end
            GAP: begin
                // A late ready echo from the responder lands here and is ignored.
                if (remaining_r == {CNT_W{1'b0}}) begin
                    state_n = DRAIN;
                end else if (free_slots_s != {OCC_W{1'b0}}) begin
                    state_n     = REQ;
                    mem_valid_n = 1'b1;
                    timer_n     = {TIMER_W{1'b0}};
                end else begin
                    state_n = GAP;
                end
            end
            DRAIN: begin
                if (fifo_empty_s) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n     = IDLE;
                mem_valid_n = 1'b0;
                busy_n      = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            mem_valid_r <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            timer_r     <= {TIMER_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            mem_valid_r <= mem_valid_n;
            addr_r      <= addr_n;
            remaining_r <= remaining_n;
            timer_r     <= timer_n;
            busy_r      <= busy_n;
            done_r      <= done_n;
            err_r       <= err_n;
        end
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_s),
        .wdata (mem_rdata),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign out_valid   = !fifo_empty_s;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_timeout = err_r;
    assign mem_valid   = mem_valid_r;
    assign mem_addr    = addr_r;
    assign mem_wstrb   = 4'b0000;

endmodule

// File: tb/tb_progmem_reader.sv
// Scoreboard bench for progmem_reader: expected words and bus addresses are
// queued at stimulus time and consumed by monitors on the falling edge.
module tb_progmem_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [15:0] word_count = 16'h0;
    logic        busy, done, err_timeout, mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_rdata, out_data;
    logic [3:0]  mem_wstrb;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    progmem_reader dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done),
        .err_timeout(err_timeout), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wstrb(mem_wstrb),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Responder: ready one cycle after valid; optional one-cycle late echo.
    logic ack_en = 1'b1;
    logic echo_mode = 1'b0;
    logic echo_r;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_ready <= 1'b0;
            echo_r    <= 1'b0;
        end else if (echo_r) begin
            mem_ready <= 1'b0;
            echo_r    <= 1'b0;
        end else if (mem_ready) begin
            mem_ready <= echo_mode;
            echo_r    <= echo_mode;
        end else begin
            mem_ready <= mem_valid && ack_en;
        end
    end
    assign mem_rdata = 32'hA000_0000 + ((mem_addr - 32'h0010_0000) >> 2);

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_w, prev_data;
    bit          prev_hold = 1'b0;
    bit          chk_vlen = 1'b1;
    int          vlen_exp = 2;
    int          vrun = 0;
    int          n_out = 0, n_hs = 0, n_done = 0, n_vrise = 0;
    int          snap_out, snap_hs, snap_done, snap_vrise;

    // Output stream, bus and done monitors
    always @(negedge clk) begin
        if (prev_hold && out_valid) begin
            checks++;
            if (out_data !== prev_data) begin
                errors++;
                $display("FAIL out_stable: out_data %h changed, required %h", out_data, prev_data);
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        if (out_valid && out_ready) begin
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_word: got %h, required no word", out_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (out_data !== exp_w) begin
                    errors++;
                    $display("FAIL out_word: got %h, required %h", out_data, exp_w);
                end
            end
        end
        if (mem_valid && mem_ready) begin
            n_hs++;
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL bus_addr: read at %h, required no read", mem_addr);
            end else begin
                exp_w = exp_addr_q.pop_front();
                if (mem_addr !== exp_w || mem_wstrb !== 4'b0000) begin
                    errors++;
                    $display("FAIL bus_addr: addr %h wstrb %b, required %h wstrb 0000",
                             mem_addr, mem_wstrb, exp_w);
                end
            end
        end
        if (mem_valid) begin
            if (vrun == 0) n_vrise++;
            vrun++;
        end else begin
            if (vrun != 0 && chk_vlen) begin
                checks++;
                if (vrun != vlen_exp) begin
                    errors++;
                    $display("FAIL valid_len: mem_valid high %0d cycles, required %0d", vrun, vlen_exp);
                end
            end
            vrun = 0;
        end
        if (done) n_done++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] base, input logic [15:0] cnt);
        @(posedge clk);
        #1;
        snap_out = n_out; snap_hs = n_hs; snap_done = n_done; snap_vrise = n_vrise;
        start = 1'b1; base_addr = base; word_count = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, (cnt != 16'd0) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_wait: no done within %0d cycles, required done=1", budget);
        end else begin
            chk("busy_at_done", busy, 32'd0);
            @(negedge clk);
            chk("done_width", done, 32'd0);
        end
    endtask

    task automatic end_job(input string name, input int words, input int reads);
        repeat (2) @(negedge clk);
        chk({name, "_words"}, n_out - snap_out, words);
        chk({name, "_reads"}, n_hs - snap_hs, reads);
        chk({name, "_done"}, n_done - snap_done, 32'd1);
        chk({name, "_pending"}, exp_q.size() + exp_addr_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_err", err_timeout, 32'd0);
        chk("rst_mem_valid", mem_valid, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;

        // Basic read of three words
        exp_q      = {32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
        exp_addr_q = {32'h0010_0000, 32'h0010_0004, 32'h0010_0008};
        start_job(32'h0010_0000, 16'd3);
        wait_done(200);
        end_job("basic", 3, 3);
        chk("basic_err", err_timeout, 32'd0);

        // Responder echoes ready one cycle late
        echo_mode  = 1'b1;
        exp_q      = {32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
        exp_addr_q = {32'h0010_0000, 32'h0010_0004, 32'h0010_0008};
        start_job(32'h0010_0000, 16'd3);
        wait_done(200);
        end_job("echo", 3, 3);
        echo_mode = 1'b0;

        // Backpressure: sink stalled for 40 cycles
        out_ready  = 1'b0;
        exp_q      = {32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                      32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007};
        exp_addr_q = {32'h0010_0000, 32'h0010_0004, 32'h0010_0008, 32'h0010_000C,
                      32'h0010_0010, 32'h0010_0014, 32'h0010_0018, 32'h0010_001C};
        start_job(32'h0010_0000, 16'd8);
        repeat (40) @(negedge clk);
        chk("bp_reads_stalled", n_hs - snap_hs, 32'd4);
        chk("bp_valid_low", mem_valid, 32'd0);
        chk("bp_out_valid", out_valid, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(300);
        end_job("bp", 8, 8);

        // Timeout: responder never acknowledges
        ack_en   = 1'b0;
        vlen_exp = 255;
        start_job(32'h0000_0000, 16'd2);
        wait_done(2000);
        end_job("timeout", 0, 0);
        chk("timeout_err", err_timeout, 32'd1);
        chk("timeout_vrise", n_vrise - snap_vrise, 32'd1);
        ack_en   = 1'b1;
        vlen_exp = 2;
        exp_q      = {32'hA000_0000};
        exp_addr_q = {32'h0010_0000};
        start_job(32'h0010_0000, 16'd1);
        chk("err_cleared", err_timeout, 32'd0);
        wait_done(200);
        end_job("after_timeout", 1, 1);

        // Zero-length job
        start_job(32'h0010_0000, 16'd0);
        chk("zero_done_next", done, 32'd1);
        wait_done(5);
        end_job("zero", 0, 0);
        chk("zero_no_valid", n_vrise - snap_vrise, 32'd0);

        // Address wrap at top of space
        exp_q      = {32'hDFFB_FFFF, 32'hDFFC_0000};
        exp_addr_q = {32'hFFFF_FFFC, 32'h0000_0000};
        start_job(32'hFFFF_FFFC, 16'd2);
        wait_done(200);
        end_job("wrap", 2, 2);

        // Misaligned base is word-aligned down
        exp_q      = {32'hA000_0000};
        exp_addr_q = {32'h0010_0000};
        start_job(32'h0010_0003, 16'd1);
        wait_done(200);
        end_job("misalign", 1, 1);

        // Reset during the second request of a five-word job
        exp_q      = {32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        exp_addr_q = {32'h0010_0000, 32'h0010_0004, 32'h0010_0008, 32'h0010_000C, 32'h0010_0010};
        start_job(32'h0010_0000, 16'd5);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if ((n_hs - snap_hs) >= 1 && mem_valid && !mem_ready) found = 1'b1;
        end
        chk("rst_mid_reached", found, 32'd1);
        chk_vlen = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_valid", mem_valid, 32'd0);
        chk("rst_mid_busy", busy, 32'd0);
        chk("rst_mid_out_valid", out_valid, 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk_vlen = 1'b1;
        exp_q      = {32'hA000_0000};
        exp_addr_q = {32'h0010_0000};
        start_job(32'h0010_0000, 16'd1);
        wait_done(200);
        end_job("post_reset", 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
